fifo_rd_stream: RTL



---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_rd_stream_if.sv | 43 ++++
 rtl/fifo_rd_stream_skid.sv | 70 +++++++
 rtl/fifo_rd_stream.sv | 68 ++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and helpers for the asynchronous FIFO and its read-side
// consumer.
//   DATA_WIDTH_DEF : default FIFO word / stream data width
//   ADDR_WIDTH_DEF : default FIFO address width (storage depth = 2**ADDR_WIDTH_DEF)
//   clog2()        : ceil(log2(n)), returns 0 for n <= 1
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if
// Groups the FIFO first-word-fall-through read port and the valid/ready output
// stream of the read-side consumer.
//   fifo_empty, fifo_rd_data : FIFO head status and word (into the consumer)
//   fifo_rd_en               : pop strobe (out of the consumer)
//   m_valid, m_data, m_last  : output stream (out of the consumer)
//   m_ready                  : downstream accept (into the consumer)
// Modport master is the consumer side, slave is the FIFO plus downstream side.
interface fifo_rd_stream_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/fifo_rd_stream_skid.sv
// rd_skid_buffer
// Two-entry buffer: a head register that drives the output stream and a skid
// register that catches a pop landing while the head is still held.
//   clk, rst    : clock, asynchronous active-high reset
//   i_push      : store i_push_data this edge (never asserted at occupancy 2)
//   i_push_data : word to store
//   i_pop       : head consumed this edge (never asserted at occupancy 0)
//   o_head      : head word
//   o_occ       : occupancy 0..2
module rd_skid_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [1:0]            r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= i_push_data;
                        r_occ  <= 2'd1;
                    end else begin
                        r_skid <= i_push_data;
                        r_occ  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_occ == 2'd2) begin
                        r_head <= r_skid;
                        r_occ  <= 2'd1;
                    end else begin
                        r_occ  <= 2'd0;
                    end
                end
                2'b11: begin
                    // Occupancy is unchanged; the older skid word must reach
                    // the head before the new word to keep FIFO order.
                    if (r_occ == 2'd2) begin
                        r_head <= r_skid;
                        r_skid <= i_push_data;
                    end else begin
                        r_head <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head = r_head;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side consumer of the asynchronous FIFO. Pops words through the
// first-word-fall-through port into a 2-entry skid buffer, presents them as a
// valid/ready stream and marks the last beat of each fixed-length burst.
//   rd_clk   : read-domain clock
//   rd_rst   : asynchronous active-high reset
//   enable   : permits popping; buffered words drain regardless
//   buf_occ  : skid buffer occupancy 0..2
//   bus      : FIFO read port and output stream (master side)
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST_LEN  = 4
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             enable,
    output logic [1:0]       buf_occ,
    fifo_rd_stream_if.master bus
);

    localparam int CNT_W = (clog2(BURST_LEN) < 1) ? 1 : clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    logic                  w_pop;
    logic                  w_xfer;
    logic [1:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic [CNT_W-1:0]      r_beat_cnt;

    // Registered occupancy only: no combinational path from m_ready to the
    // pop strobe. rd_rst is included so no pop is signalled during reset.
    assign w_pop  = enable & ~bus.fifo_empty & (w_occ < 2'd2) & ~rd_rst;
    assign w_xfer = bus.m_valid & bus.m_ready;

    rd_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (rd_clk),
        .rst         (rd_rst),
        .i_push      (w_pop),
        .i_push_data (bus.fifo_rd_data),
        .i_pop       (w_xfer),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    // Beat count survives enable gaps; only reset restarts a burst.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_beat_cnt <= '0;
        end else if (w_xfer) begin
            if (r_beat_cnt == LAST_BEAT) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en = w_pop;
    assign bus.m_valid    = (w_occ != 2'd0);
    assign bus.m_data     = w_head;
    assign bus.m_last     = bus.m_valid & (r_beat_cnt == LAST_BEAT);
    assign buf_occ        = w_occ;

endmodule
